uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two, at least 2.
REQ-002 The block SHALL have port clk50m, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-005 The block SHALL have port rx_ready, input, 1 bit: level flag from the receiver; it rises once per received byte and stays high until the next start bit.
REQ-006 The block SHALL have port rx_error, input, 1 bit: framing-error flag, valid in the same cycle rx_ready rises.
REQ-007 The block SHALL have port rd_en, input, 1 bit: consumer pop request.
REQ-008 The block SHALL have port rd_data, output, 8 bits: head-of-FIFO byte (show-ahead).
REQ-009 The block SHALL have port rd_err, output, 1 bit: error tag of the head entry; present only with UART_RX_FIFO_ERR_TAG_EN.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: FIFO not empty.
REQ-011 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, range 0..DEPTH.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is lost because the FIFO is full.
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: one-cycle clear strobe for overflow.

Function
REQ-015 The block SHALL register rx_ready each cycle and generate push = rx_ready AND NOT rx_ready_q, giving exactly one push per rising edge.
REQ-016 On push, the block SHALL write rx_data, plus rx_error when tagging is enabled, to mem[wr_ptr] and advance wr_ptr by 1 modulo DEPTH.
REQ-017 The block SHALL treat pop = rd_en AND rd_valid; on pop, rd_ptr advances by 1 modulo DEPTH. A pop while empty SHALL be ignored with no state change.
REQ-018 rd_data and rd_err SHALL be driven combinationally from mem[rd_ptr]; the head is visible with 1-cycle latency after the push edge.
REQ-019 On push with no pop: count +1. On pop with no push: count -1. On push and pop together: count is unchanged and both pointers advance.
REQ-020 A push while full with a simultaneous pop SHALL be accepted.
REQ-021 A push while full without a pop SHALL be dropped and SHALL set overflow; memory, pointers and count are unchanged.
REQ-022 A push and a pop in the same cycle while empty SHALL perform only the push; rd_valid rises next cycle.
REQ-023 ovf_clr SHALL clear overflow next cycle; if a set condition occurs in the same cycle, set SHALL win.
REQ-024 rd_valid and full SHALL be decoded from the registered count, with no combinational path from rd_en.

Reset
REQ-025 While rst is high, on each clk50m edge the block SHALL load wr_ptr=0, rd_ptr=0, count=0, overflow=0 and rx_ready_q=1.
REQ-026 Because rx_ready_q resets to 1, an rx_ready held high through reset SHALL NOT produce a push.
REQ-027 During and after reset, rd_valid=0, full=0, count=0 and overflow=0; rd_data and rd_err are don't-care while rd_valid=0.
REQ-028 The block SHALL NOT reset the memory array; a reset mid-operation discards all contents and any in-flight push.

Configuration
REQ-029 With macro UART_RX_FIFO_ERR_TAG_EN defined, entries SHALL be 9 bits (error bit plus data) and port rd_err SHALL exist.
REQ-030 Without UART_RX_FIFO_ERR_TAG_EN, entries SHALL be 8 bits, port rd_err SHALL be absent, and a rising rx_ready with rx_error=1 SHALL be discarded (no push, no overflow).

Structure
REQ-031 Package uart_pkg SHALL hold: BYTE_W=8; typedef rx_entry_t (packed struct with err and data); typedef byte_t.
REQ-032 Rising-edge detection SHALL be in a sub-module rise_det (ports clk50m, rst, d, rise) with reset value 1; the FIFO core stays in uart_rx_fifo.

Verification
REQ-033 Single byte: after reset, pulse rx_ready high with rx_data=8'hA5, rx_error=0, and hold it high 100 cycles -> exactly one entry; count=1, rd_valid=1, rd_data=8'hA5 one cycle later.
REQ-034 Fill and drain: push 16 bytes 8'h00..8'h0F with DEPTH=16 -> full=1, count=16; then rd_en for 16 cycles -> data 00..0F in order, then rd_valid=0 and count=0.
REQ-035 Overflow: push a 17th byte 8'hFF while full without rd_en -> overflow=1, count=16, head still 8'h00; pulse ovf_clr -> overflow=0 next cycle.
REQ-036 Full with simultaneous pop: while full, push 8'h55 with rd_en=1 -> count stays 16, overflow=0, and 8'h55 is read last after draining.
REQ-037 Error tag: push 8'h3C with rx_error=1 -> with UART_RX_FIFO_ERR_TAG_EN, rd_err=1 and rd_data=8'h3C; without it, count stays 0.
REQ-038 Reset mid-operation: with 5 entries and rx_ready held high, assert rst for 1 cycle -> count=0, rd_valid=0, and no push occurs until rx_ready falls and rises again.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive FIFO.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef struct packed {
        logic  err;
        byte_t data;
    } rx_entry_t;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for a level flag. The history register resets to 1 so a
// level that is already high when reset releases is never seen as an edge.
module rise_det (
    input  logic clk50m,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_q;

    // Remember last cycle's level; reset to 1 to suppress a false edge.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            r_q <= 1'b1;
        end else begin
            r_q <= d;
        end
    end

    assign rise = d & ~r_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO that captures one byte per rising edge of the receiver's
// rx_ready level flag.
// Optional feature: define UART_RX_FIFO_ERR_TAG_EN to store the framing-error
// bit with each byte and expose it on rd_err. Without it, errored bytes are
// discarded at the input.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk50m,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        rx_data,
    input  logic                     rx_ready,
    input  logic                     rx_error,
    input  logic                     rd_en,
    output logic [BYTE_W-1:0]        rd_data,
`ifdef UART_RX_FIFO_ERR_TAG_EN
    output logic                     rd_err,
`endif
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_rise;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr_en;
    logic w_ovf_set;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    rx_entry_t r_mem [DEPTH];
    rx_entry_t w_wr_entry;
`else
    byte_t     r_mem [DEPTH];
    byte_t     w_wr_entry;
`endif

    rise_det u_rise_det (
        .clk50m (clk50m),
        .rst    (rst),
        .d      (rx_ready),
        .rise   (w_rise)
    );

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign w_push        = w_rise;
    assign w_wr_entry    = '{err: rx_error, data: rx_data};
    assign rd_data       = r_mem[r_rd_ptr].data;
    assign rd_err        = r_mem[r_rd_ptr].err;
`else
    // Errored bytes never enter the FIFO and cannot cause an overflow.
    assign w_push        = w_rise & ~rx_error;
    assign w_wr_entry    = rx_data;
    assign rd_data       = r_mem[r_rd_ptr];
`endif

    // Status comes only from the registered count, never from rd_en.
    assign w_full    = (r_count == FULL_CNT);
    assign rd_valid  = (r_count != '0);
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;

    assign w_pop     = rd_en & rd_valid;
    // A push while full is still accepted when a pop frees the head slot.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    // Storage write; memory is not reset, and a push in a reset cycle is dropped.
    always_ff @(posedge clk50m) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers and occupancy; wrap is implicit because DEPTH is a power of two.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overflow; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
